// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package seq_div_pkg;

  // Controller states: wait for a request, iterate, apply signs.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DIV_DEFAULT_WIDTH = 32;

  // Widest operand abs_u can handle; callers zero-extend into this width.
  localparam int ABS_MAX_W = 64;

  // Unsigned magnitude of the low 'width' bits of val, read as two's complement.
  // The most negative value maps to 2^(width-1), which is exact as unsigned.
  function automatic logic [ABS_MAX_W-1:0] abs_u(input logic [ABS_MAX_W-1:0] val,
                                                 input int unsigned         width);
    logic [ABS_MAX_W-1:0] mask;
    logic [ABS_MAX_W-1:0] res;
    logic [5:0]           sign_idx;
    sign_idx = 6'(width - 32'd1);
    if (width >= 32'(ABS_MAX_W)) begin
      mask = {ABS_MAX_W{1'b1}};
    end else begin
      mask = (64'd1 << width) - 64'd1;
    end
    if (val[sign_idx] == 1'b1) begin
      res = (~val + 64'd1) & mask;
    end else begin
      res = val & mask;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor magnitude, keep the difference only when it is non-negative.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs_mag,
  output logic [WIDTH:0]   p_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] p_shift_s;
  logic [WIDTH:0]   diff_s;
  logic             ge_s;

  // Trial subtraction; the compare is done at full width so the borrow never wraps.
  always_comb begin
    p_shift_s = {p_in, dvd_bit};
    ge_s      = (p_shift_s >= {2'b00, dvs_mag});
    diff_s    = p_shift_s[WIDTH:0] - {1'b0, dvs_mag};
    if (ge_s) begin
      q_bit = 1'b1;
      p_out = diff_s;
    end else begin
      q_bit = 1'b0;
      p_out = p_shift_s[WIDTH:0];
    end
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient
// bit per cycle, then a single sign-fix cycle. Truncates toward zero.
module seq_signed_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;             // partial remainder
  logic [WIDTH-1:0] q_q, q_d;             // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;         // divisor magnitude
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sq_q, sq_d;           // quotient negative
  logic             sr_q, sr_d;           // remainder negative (dividend sign)
  logic             zero_q, zero_d;       // divisor was zero
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_p_s;
  logic             step_qbit_s;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .p_in    (p_q),
    .dvd_bit (q_q[WIDTH-1]),
    .dvs_mag (dvs_q),
    .p_out   (step_p_s),
    .q_bit   (step_qbit_s)
  );

  // Next-state, datapath and output computation for the divide sequence.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    sq_d        = sq_q;
    sr_d        = sr_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          q_d    = WIDTH'(abs_u(ABS_MAX_W'(dividend), WIDTH));
          dvs_d  = WIDTH'(abs_u(ABS_MAX_W'(divisor), WIDTH));
          sq_d   = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sr_d   = dividend[WIDTH-1];
          p_d    = {(WIDTH+1){1'b0}};
          cnt_d  = {CNT_W{1'b0}};
          busy_d = 1'b1;
          if (divisor == {WIDTH{1'b0}}) begin
            zero_d  = 1'b1;
            state_d = FIX;
          end else begin
            zero_d  = 1'b0;
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        p_d   = step_p_s;
        q_d   = {q_q[WIDTH-2:0], step_qbit_s};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end

      FIX: begin
        if (zero_q) begin
          // q_q still holds |dividend|; re-applying the sign restores the dividend.
          quotient_d  = {WIDTH{1'b1}};
          remainder_d = sr_q ? ({WIDTH{1'b0}} - q_q) : q_q;
          dbz_d       = 1'b1;
        end else begin
          // MIN / -1 falls out naturally: -(2^(W-1)) truncates back to MIN.
          quotient_d  = sq_q ? ({WIDTH{1'b0}} - q_q) : q_q;
          remainder_d = sr_q ? ({WIDTH{1'b0}} - p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
          dbz_d       = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      p_q         <= {(WIDTH+1){1'b0}};
      q_q         <= {WIDTH{1'b0}};
      dvs_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      sq_q        <= sq_d;
      sr_q        <= sr_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider against an arithmetic reference.
module tb_seq_signed_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           c;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // C semantics: truncate toward zero, remainder takes the dividend's sign.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
    exp_t e;
    int signed sa;
    int signed sbv;
    int signed qq;
    int signed rr;
    sa = a;
    sbv = b;
    e.c = c;
    if (sbv == 0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else if (sa == -2147483647 - 1 && sbv == -1) begin
      e.q = a;
      e.r = '0;
      e.z = 1'b0;
    end else begin
      qq = sa / sbv;
      rr = sa % sbv;
      e.q = qq;
      e.r = rr;
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Drive a request at the current negedge and predict its result and completion cycle.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    lat = (b == '0) ? 1 : W + 1;
    start = 1'b1;
    dividend = a;
    divisor = b;
    sb.push_back(model(a, b, cyc + 1 + lat));
  endtask

  // Wait (bounded) for done, checking busy stays high until then.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
        check("busy_at_done", 64'(busy), 64'd0);
      end else begin
        check("busy_during", 64'(busy), 64'd1);
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done expected=done");
    end
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  // Monitor: compare every done pulse against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      check("done_pulse_width", 64'(prev_done), 64'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done expected=none");
      end else begin
        e = sb.pop_front();
        check("quotient", 64'(quotient), 64'(e.q));
        check("remainder", 64'(remainder), 64'(e.r));
        check("div_by_zero", 64'(div_by_zero), 64'(e.z));
        check("done_cycle", 64'(cyc), 64'(e.c));
      end
    end
    prev_done <= done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    repeat (2) @(negedge clk);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_div(32'd100, 32'd7);
    run_div(-32'sd100, 32'd7);
    run_div(32'd100, -32'sd7);
    run_div(-32'sd100, -32'sd7);
    run_div(32'd7, -32'sd100);
    run_div(32'h8000_0000, 32'hFFFF_FFFF);
    run_div(32'h8000_0000, 32'd1);
    run_div(32'd1234, 32'd0);

    // Results from the zero divide stay visible while the next divide runs.
    issue(32'd9, 32'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("held_quotient", 64'(quotient), 64'hFFFF_FFFF);
    check("held_dbz", 64'(div_by_zero), 64'd1);
    wait_done();

    // A second start while busy must be ignored.
    issue(32'd100, 32'd7);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    dividend = 32'd5;
    divisor = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Randomised divides, issued back-to-back in each done cycle.
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'd0 - 32'($urandom_range(1, 20));
        default: b = (i % 5 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 30));
      endcase
      run_div(a, b);
    end
    @(negedge clk);

    // Reset in the middle of an operation aborts it.
    issue(32'd1000, 32'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_quotient", 64'(quotient), 64'd0);
    check("abort_remainder", 64'(remainder), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_dbz", 64'(div_by_zero), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) begin
        checks++;
        errors++;
        $display("FAIL no_done_after_abort actual=1 expected=0");
      end
    end
    checks++;
    run_div(32'd55, 32'd5);
    @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_signed_divider.md
# seq_signed_divider

Sequential signed integer divider for the multiplier datapath. It performs the inverse operation of the sequential radix-4 Booth multiplier: it accepts a 32-bit two's-complement dividend and divisor and produces quotient and remainder with C/RISC-V semantics. The algorithm is restoring division on magnitudes, one quotient bit per cycle, followed by one sign-fix cycle. It shares the multiplier's start-pulse style and adds busy/done handshaking.

## Interface
- WIDTH, 32, operand/result width in bits; must be even and at least 4.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  WIDTH  signed numerator; captured when start is accepted.
- divisor  in  WIDTH  signed denominator; captured when start is accepted.
- quotient  out  WIDTH  signed quotient; held until the next accepted start.
- remainder  out  WIDTH  signed remainder; held until the next accepted start.
- busy  out  1  high from acceptance until done.
- done  out  1  one-cycle pulse when results become valid.
- div_by_zero  out  1  flag qualified by done; held with the results.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1:
  - Capture operands.
  - Store the magnitudes |dividend| and |divisor|, treating them as unsigned WIDTH-bit values so that MIN magnitude is 2^(WIDTH-1).
  - Store the signs sq = sign(dividend) XOR sign(divisor) and sr = sign(dividend).
  - Clear the partial remainder P (WIDTH+1 bits) and the iteration counter.
  - If divisor == 0, go to FIX with the zero flag set. Otherwise go to CALC.
- CALC, one iteration per cycle, WIDTH iterations:
  - Shift {P, Q} left by 1, bringing in the dividend magnitude MSB first.
  - Compute T = P - |divisor| at WIDTH+1 bits.
  - If T ≥ 0, set P = T and the new Q bit to 1. Otherwise keep P and set the Q bit to 0.
  - After iteration WIDTH, go to FIX.
- FIX, one cycle:
  - Normal case: quotient = sq ? -Q : Q and remainder = sr ? -P : P, both truncated to WIDTH bits.
  - Divide by zero: quotient = all ones (-1), remainder = dividend, div_by_zero = 1.
  - Overflow (MIN / -1): the normal path yields quotient = MIN and remainder = 0. This is required; no special case is needed.
  - Assert done, deassert busy, return to IDLE.
- Division truncates toward zero. A nonzero remainder has the sign of the dividend, and |remainder| < |divisor|.
- start while busy is ignored and has no effect on the operation in flight.

## Timing
- Reset: state = IDLE; quotient, remainder, busy, done, div_by_zero and all internal registers = 0.
- Start accepted at edge t:
  - busy = 1 after edge t.
  - Normal divide: done = 1 after edge t+WIDTH+1 (33 for WIDTH=32). Results update on the same edge.
  - Divide by zero: done = 1 after edge t+1.
- done is high for exactly one cycle. busy falls on the same edge done rises.
- start = 1 in the done cycle is accepted: the state is IDLE, so a new operation begins on the next edge without an idle gap. Previous results remain visible until the FIX of the new operation.
- Reset asserted mid-operation: the operation is aborted immediately and asynchronously, and all outputs return to 0. No done is produced.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package seq_div_pkg:
  - state enum {IDLE, CALC, FIX};
  - DIV_DEFAULT_WIDTH = 32;
  - function abs_u(width) returning the unsigned magnitude.
- Sub-module div_restore_step: combinational, parameter WIDTH.
  - Inputs: P (WIDTH+1), next dividend bit, |divisor|.
  - Outputs: new P and the quotient bit.
  - It is instantiated once. The FSM/counter, operand registers and sign fix stay in the top.

## Test plan
- 100 / 7 → quotient 14, remainder 2, div_by_zero 0. done exactly 33 cycles after the start edge; busy high in between.
- -100 / 7 → -14, -2. 100 / -7 → -14, 2. -100 / -7 → 14, -2. 7 / -100 → 0, 7.
- 0x80000000 / -1 → quotient 0x80000000, remainder 0. 0x80000000 / 1 → 0x80000000, 0.
- 1234 / 0 → quotient 0xFFFFFFFF, remainder 1234, div_by_zero 1, done 1 cycle after start. A following 9 / 3 → 3, 0 with div_by_zero 0.
- start pulsed again at cycle 10 of a 100/7 with different operands → ignored, result still 14/2. start held in the done cycle → back-to-back operation completes 33 cycles later.
- rst_n low at cycle 15 of an operation → all outputs 0 immediately, no done. After release, 55 / 5 → 11, 0.
